y86_regfile_writer: RTL and testbench
=====================================

# y86_regfile_writer

Write-side initiator for the Y86 dual-write-port register file. It accepts writeback requests (dstE/valE, dstM/valM) from the pipeline's writeback stage through a valid/ready handshake and buffers them in a small FIFO. It drains them onto the register file's two write ports as strobed, pulse-separated writes. It also applies Y86 destination-conflict rules and, optionally, forwards pending values to decode-stage readers.

## Interface
Parameters:
- DATA_W, 32, register value width
- DEPTH, 4, request FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  writeback request present
- wb_ready  out  1  FIFO can accept; high when not full
- wb_dstE  in  4  E destination register ID; 4'hF = RNONE (no write)
- wb_valE  in  DATA_W  E value
- wb_dstM  in  4  M destination register ID; 4'hF = RNONE
- wb_valM  in  DATA_W  M value
- write1  out  1  port-1 (E) write strobe
- register1  out  4  port-1 register ID
- value1  out  DATA_W  port-1 data
- write2  out  1  port-2 (M) write strobe
- register2  out  4  port-2 register ID
- value2  out  DATA_W  port-2 data
- busy  out  1  FIFO non-empty or FSM not IDLE
- fwd_id  in  4  register ID probed by decode (FORWARD only)
- fwd_hit  out  1  pending write to fwd_id exists (FORWARD only)
- fwd_val  out  DATA_W  youngest pending value for fwd_id (FORWARD only)

## Operation
- Enqueue on wb_valid && wb_ready. A request with both IDs = RNONE is accepted and discarded, with no FIFO entry.
- Conflict rule: dstE == dstM ≠ RNONE clears the E half at enqueue, so M wins (popl %esp semantics).
- FSM states:
  - IDLE: when FIFO non-empty → PULSE.
  - PULSE: write1 = (dstE ≠ RNONE), write2 = (dstM ≠ RNONE); register/value driven from the FIFO head; head popped → GAP.
  - GAP: both strobes low; register/value hold the last values → IDLE.
- Each strobe is high for exactly one cycle and low for at least one cycle between writes. The file writes on a strobe change, so a held strobe would drop writes.
- Write order equals acceptance order. There is no reordering and no merging.
- Simultaneous enqueue and pop while full: wb_ready is computed from the current count, so no enqueue occurs that cycle.
- Reset mid-operation: FIFO emptied, FSM → IDLE, pending requests are lost, and a strobe in progress drops the same edge.

## Timing
- Reset values: wb_ready=1, write1=write2=0, register1=register2=4'hF, value1=value2=0, busy=0, fwd_hit=0, fwd_val=0.
- Latency: a request accepted at edge N into an empty, IDLE block raises its strobes in cycle N+2 (N+1: FSM IDLE→PULSE registered).
- Throughput: one request per 3 cycles (IDLE, PULSE, GAP). GAP→PULSE directly when the FIFO is non-empty is allowed and gives 1 per 2 cycles, which is required.
- wb_ready deasserts in the cycle after the count reaches DEPTH.
- Pointer wrap: log2(DEPTH)-bit pointers plus an extra count bit; full/empty are derived from the count.

## Configuration
- Y86_WB_FORWARD_EN defined:
  - fwd_hit/fwd_val are combinational over all valid FIFO entries plus the entry in PULSE, youngest match wins.
  - M beats E within an entry.
  - RNONE never hits.
- Not defined: fwd_id is ignored, and fwd_hit/fwd_val are tied to 0.

## Structure
- Package y86_pkg:
  - RNONE = 4'hF
  - register ID constants (EAX…EDI)
  - REG_ID_W = 4
  - writeback request struct {dstE, valE, dstM, valM}
  - FSM state enum {IDLE, PULSE, GAP}
- Sub-module wb_req_fifo: a parameterized synchronous FIFO of request structs exposing all entries for the forwarding search. The FSM, the conflict rule and forwarding live in the top module.

## Test plan
- Reset, then a single request dstE=0 valE=0x11 dstM=RNONE → cycle N+2: write1=1 register1=0 value1=0x11, write2=0; next cycle write1=0.
- Back-to-back requests dstE=1 valE=0xA, then dstE=2 valE=0xB → two pulses separated by exactly one low cycle, in order 1 then 2.
- Conflict dstE=dstM=4 valE=0x5 valM=0x9 → only write2=1 register2=4 value2=0x9; write1 stays 0.
- Fill 4 requests while the FSM is stalled in the first write → wb_ready=0 after the fourth, 5th held valid is not accepted until the first pop, and all 5 are written in order.
- FORWARD_EN: pending dstM=3 valM=0x77 then dstE=3 valE=0x88, fwd_id=3 → fwd_hit=1 fwd_val=0x88; after both drain, fwd_hit=0.
- Assert rst_n low during PULSE with 3 entries queued → strobes drop immediately, busy=0, and no further writes after release.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 writeback types: register IDs, request layout and writer FSM states.
package y86_pkg;

  localparam int REG_ID_W = 4;
  localparam int WORD_W   = 32;

  localparam logic [REG_ID_W-1:0] EAX   = 4'h0;
  localparam logic [REG_ID_W-1:0] ECX   = 4'h1;
  localparam logic [REG_ID_W-1:0] EDX   = 4'h2;
  localparam logic [REG_ID_W-1:0] EBX   = 4'h3;
  localparam logic [REG_ID_W-1:0] ESP   = 4'h4;
  localparam logic [REG_ID_W-1:0] EBP   = 4'h5;
  localparam logic [REG_ID_W-1:0] ESI   = 4'h6;
  localparam logic [REG_ID_W-1:0] EDI   = 4'h7;
  localparam logic [REG_ID_W-1:0] RNONE = 4'hF;

  typedef struct packed {
    logic [REG_ID_W-1:0] dstE;
    logic [WORD_W-1:0]   valE;
    logic [REG_ID_W-1:0] dstM;
    logic [WORD_W-1:0]   valM;
  } wbReq_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } wbState_t;

endpackage

// File: rtl/wb_req_fifo.sv
// Synchronous FIFO of writeback requests; every slot is visible for the forwarding search.
// Full/empty come from a count one bit wider than the pointers.
module wb_req_fifo
  import y86_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = wbReq_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  ENTRY_T                 pushData,
  input  logic                   pop,
  output ENTRY_T                 headData,
  output ENTRY_T [DEPTH-1:0]     entries,
  output logic [CNT_W-1:0]       count,
  output logic [PTR_W-1:0]       rdPtr,
  output logic                   full,
  output logic                   empty
);

  ENTRY_T [DEPTH-1:0] mem;
  logic [PTR_W-1:0]   wrPtr;
  logic               doPush;
  logic               doPop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign doPush   = push && !full;
  assign doPop    = pop && !empty;
  assign headData = mem[rdPtr];
  assign entries  = mem;

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      unique case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/y86_regfile_writer.sv
// Buffers Y86 writeback requests and drains them as one-cycle, gap-separated strobes on two write ports.
// Optional decode-stage forwarding of pending values is built when Y86_WB_FORWARD_EN is defined.
module y86_regfile_writer
  import y86_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        wb_dstE,
  input  logic [DATA_W-1:0] wb_valE,
  input  logic [3:0]        wb_dstM,
  input  logic [DATA_W-1:0] wb_valM,
  output logic              write1,
  output logic [3:0]        register1,
  output logic [DATA_W-1:0] value1,
  output logic              write2,
  output logic [3:0]        register2,
  output logic [DATA_W-1:0] value2,
  output logic              busy,
  input  logic [3:0]        fwd_id,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_val
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [REG_ID_W-1:0] dstE;
    logic [DATA_W-1:0]   valE;
    logic [REG_ID_W-1:0] dstM;
    logic [DATA_W-1:0]   valM;
  } reqT;

  wbState_t          state, stateNext;
  reqT               inReq, headReq;
  reqT [DEPTH-1:0]   entries;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rdPtr;
  logic              push, pop, full, empty, inPulse;
  logic [3:0]        heldReg1, heldReg2;
  logic [DATA_W-1:0] heldVal1, heldVal2;

  // Same destination on both halves: M wins, as popl %esp requires.
  always_comb begin
    inReq = '{dstE: wb_dstE, valE: wb_valE, dstM: wb_dstM, valM: wb_valM};
    if (wb_dstE == wb_dstM && wb_dstM != RNONE) inReq.dstE = RNONE;
  end

  assign wb_ready = !full;
  assign push     = wb_valid && wb_ready && !(wb_dstE == RNONE && wb_dstM == RNONE);
  assign inPulse  = (state == PULSE);
  assign pop      = inPulse;

  wb_req_fifo #(.DEPTH(DEPTH), .ENTRY_T(reqT)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pushData (inReq),
    .pop      (pop),
    .headData (headReq),
    .entries  (entries),
    .count    (count),
    .rdPtr    (rdPtr),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (!empty) stateNext = PULSE;
      PULSE:   stateNext = GAP;
      GAP:     stateNext = empty ? IDLE : PULSE;
      default: stateNext = IDLE;
    endcase
  end

  // Ports keep showing the last written entry outside PULSE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heldReg1 <= RNONE;
      heldReg2 <= RNONE;
      heldVal1 <= '0;
      heldVal2 <= '0;
    end else if (inPulse) begin
      heldReg1 <= headReq.dstE;
      heldReg2 <= headReq.dstM;
      heldVal1 <= headReq.valE;
      heldVal2 <= headReq.valM;
    end
  end

  assign write1    = inPulse && (headReq.dstE != RNONE);
  assign write2    = inPulse && (headReq.dstM != RNONE);
  assign register1 = inPulse ? headReq.dstE : heldReg1;
  assign value1    = inPulse ? headReq.valE : heldVal1;
  assign register2 = inPulse ? headReq.dstM : heldReg2;
  assign value2    = inPulse ? headReq.valM : heldVal2;
  assign busy      = !empty || (state != IDLE);

`ifdef Y86_WB_FORWARD_EN
  logic [PTR_W-1:0] idx;

  // Scan oldest to youngest so later matches overwrite earlier ones; M checked after E.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = '0;
    idx     = '0;
    if (fwd_id != RNONE) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = rdPtr + PTR_W'(i);
        if (CNT_W'(i) < count) begin
          if (entries[idx].dstE == fwd_id) begin
            fwd_hit = 1'b1;
            fwd_val = entries[idx].valE;
          end
          if (entries[idx].dstM == fwd_id) begin
            fwd_hit = 1'b1;
            fwd_val = entries[idx].valM;
          end
        end
      end
    end
  end
`else
  logic unusedFwd;
  assign unusedFwd = ^{fwd_id, entries, count, rdPtr};
  assign fwd_hit   = 1'b0;
  assign fwd_val   = '0;
`endif

endmodule

// File: tb/tb_y86_regfile_writer.sv
// Randomized bench for y86_regfile_writer against a queue-based model of pending writes.
module tb_y86_regfile_writer;
  import y86_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk, rst_n;
  logic              wb_valid, wb_ready;
  logic [3:0]        wb_dstE, wb_dstM;
  logic [DATA_W-1:0] wb_valE, wb_valM;
  logic              write1, write2, busy, fwd_hit;
  logic [3:0]        register1, register2, fwd_id;
  logic [DATA_W-1:0] value1, value2, fwd_val;

  y86_regfile_writer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dstE(wb_dstE), .wb_valE(wb_valE), .wb_dstM(wb_dstM), .wb_valM(wb_valM),
    .write1(write1), .register1(register1), .value1(value1),
    .write2(write2), .register2(register2), .value2(value2),
    .busy(busy), .fwd_id(fwd_id), .fwd_hit(fwd_hit), .fwd_val(fwd_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model: accepted requests not yet retired; the head stays listed during its write cycle.
  wbReq_t pending[$];
  int     strobeCyc[$];
  int     cyc = 0, nStrobes = 0;
  bit     popNext = 0, prevStrobe = 0, prevW1 = 0, prevW2 = 0, sawNotReady = 0;
  logic [3:0]        lastR1 = 4'hF, lastR2 = 4'hF;
  logic [DATA_W-1:0] lastV1 = '0, lastV2 = '0;

  initial begin : monitor
    wbReq_t e;
    bit     strobe, expHit;
    logic [DATA_W-1:0] expVal;
    forever begin
      @(negedge clk);
      cyc++;
      if (popNext) begin
        void'(pending.pop_front());
        popNext = 0;
      end
      if (!rst_n) begin
        pending.delete();
        prevStrobe = 0; prevW1 = 0; prevW2 = 0;
        chk("reset_outputs",
            {wb_ready, write1, write2, register1, register2, value1, value2, busy, fwd_hit, fwd_val},
            {1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0});
      end else begin
        strobe = write1 || write2;
        if (!wb_ready) sawNotReady = 1;
        chk("ready", wb_ready, pending.size() < DEPTH);
        chk("busy", busy, pending.size() > 0 || prevStrobe);
        chk("strobe_gap", strobe && prevStrobe, 1'b0);
        if (strobe) begin
          nStrobes++;
          strobeCyc.push_back(cyc);
          if (pending.size() == 0) begin
            chk("spurious_write", 1'b1, 1'b0);
          end else begin
            e = pending[0];
            chk("port1", {write1, write1 ? {register1, value1} : 36'h0},
                {e.dstE != 4'hF, (e.dstE != 4'hF) ? {e.dstE, e.valE} : 36'h0});
            chk("port2", {write2, write2 ? {register2, value2} : 36'h0},
                {e.dstM != 4'hF, (e.dstM != 4'hF) ? {e.dstM, e.valM} : 36'h0});
            if (e.dstE != 4'hF) begin lastR1 = e.dstE; lastV1 = e.valE; end
            if (e.dstM != 4'hF) begin lastR2 = e.dstM; lastV2 = e.valM; end
            popNext = 1;
          end
        end else begin
          if (prevW1) chk("hold1", {register1, value1}, {lastR1, lastV1});
          if (prevW2) chk("hold2", {register2, value2}, {lastR2, lastV2});
        end
        expHit = 0;
        expVal = '0;
`ifdef Y86_WB_FORWARD_EN
        if (fwd_id != 4'hF) begin
          for (int i = pending.size() - 1; i >= 0; i--) begin
            if (pending[i].dstM == fwd_id) begin expHit = 1; expVal = pending[i].valM; break; end
            if (pending[i].dstE == fwd_id) begin expHit = 1; expVal = pending[i].valE; break; end
          end
        end
`endif
        chk("forward", {fwd_hit, fwd_val}, {expHit, expVal});
        if (wb_valid && wb_ready && !(wb_dstE == 4'hF && wb_dstM == 4'hF)) begin
          e.dstE = (wb_dstE == wb_dstM) ? 4'hF : wb_dstE;
          e.valE = wb_valE;
          e.dstM = wb_dstM;
          e.valM = wb_valM;
          pending.push_back(e);
        end
        prevStrobe = strobe;
        prevW1 = write1;
        prevW2 = write2;
      end
    end
  end

  function automatic logic [3:0] rndId();
    return ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 7));
  endfunction

  // Called and returns #1 after a rising edge; the request is accepted on the edge before return.
  task automatic sendReq(input logic [3:0] dE, input logic [31:0] vE,
                         input logic [3:0] dM, input logic [31:0] vM);
    int guard = 0;
    wb_valid = 1'b1;
    wb_dstE = dE; wb_valE = vE; wb_dstM = dM; wb_valM = vM;
    @(negedge clk);
    while (!wb_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 50) chk("ready_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((busy || pending.size() != 0) && guard < 200) begin
      guard++;
      @(posedge clk); #1;
    end
    if (guard >= 200) chk("drain_timeout", 1'b0, 1'b1);
    idleCycles(1);
  endtask

  initial begin : stimulus
    int n0, savedStrobes, guard;
    logic [3:0] dE, dM;
    rst_n = 1'b0; wb_valid = 1'b0; fwd_id = 4'h0;
    wb_dstE = 4'hF; wb_dstM = 4'hF; wb_valE = '0; wb_valM = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency from an idle block.
    sendReq(EAX, 32'h11, RNONE, 32'h0);
    @(negedge clk); chk("lat_idle_cycle", write1, 1'b0);
    @(negedge clk); chk("lat_pulse", {write1, write2, register1, value1}, {1'b1, 1'b0, 4'h0, 32'h11});
    @(negedge clk); chk("lat_drop", write1, 1'b0);
    @(posedge clk); #1;
    waitDrain();

    // Back-to-back requests: one low cycle between pulses.
    n0 = strobeCyc.size();
    sendReq(ECX, 32'hA, RNONE, 32'h0);
    sendReq(EDX, 32'hB, RNONE, 32'h0);
    waitDrain();
    chk("b2b_count", strobeCyc.size() - n0, 2);
    if (strobeCyc.size() - n0 == 2) chk("b2b_spacing", strobeCyc[n0 + 1] - strobeCyc[n0], 2);

    // Destination conflict.
    sendReq(ESP, 32'h5, ESP, 32'h9);
    guard = 0;
    while (!(write1 || write2) && guard < 10) begin
      guard++;
      @(posedge clk); #1;
    end
    chk("conflict", {write1, write2, register2, value2}, {1'b0, 1'b1, 4'h4, 32'h9});
    waitDrain();

    // Fill beyond depth.
    sawNotReady = 0;
    for (int i = 0; i < 8; i++) sendReq(4'(i), 32'h100 + i, RNONE, 32'h0);
    chk("fill_not_ready", sawNotReady, 1'b1);
    waitDrain();

    // Forwarding probe.
    fwd_id = EBX;
    sendReq(RNONE, 32'h0, EBX, 32'h77);
    sendReq(EBX, 32'h88, RNONE, 32'h0);
`ifdef Y86_WB_FORWARD_EN
    chk("fwd_pending", {fwd_hit, fwd_val}, {1'b1, 32'h88});
`else
    chk("fwd_pending", {fwd_hit, fwd_val}, {1'b0, 32'h0});
`endif
    waitDrain();
    chk("fwd_drained", fwd_hit, 1'b0);

    // Reset in the middle of a write with entries queued.
    for (int i = 0; i < 4; i++) sendReq(4'(i), 32'h200 + i, RNONE, 32'h0);
    guard = 0;
    while (!(write1 || write2) && guard < 10) begin
      guard++;
      @(posedge clk); #1;
    end
    chk("pre_reset_strobe", write1, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset_async", {write1, write2, busy, wb_ready}, {1'b0, 1'b0, 1'b0, 1'b1});
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    savedStrobes = nStrobes;
    @(posedge clk); #1;
    idleCycles(10);
    chk("no_writes_after_reset", nStrobes, savedStrobes);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      dE = rndId();
      dM = rndId();
      if ($urandom_range(0, 5) == 0) dM = dE;
      fwd_id = rndId();
      sendReq(dE, $urandom, dM, $urandom);
      if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 3));
    end
    waitDrain();
    chk("final_empty", pending.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
